// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: fetch FSM states, reset/bubble defaults
// and the word-alignment helper used for redirect targets.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DROP
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding slot for a response that IF/ID could not take.
// Flush wins over push/pop; a simultaneous pop and push leaves the new entry.
module fetch_skid_buffer (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [31:0] push_instr,
   input  logic [31:0] push_pc,
   output logic        full,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   logic        full_q,  full_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q,    pc_d;

   always_comb begin
      full_d  = full_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush) begin
         full_d = 1'b0;
      end else begin
         if (pop) full_d = 1'b0;
         if (push) begin
            full_d  = 1'b1;
            instr_d = push_instr;
            pc_d    = push_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         full_q  <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         full_q  <= full_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign full      = full_q;
   assign out_instr = instr_q;
   assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC, single-outstanding fetch FSM over a valid/ready imem port,
// and the IF/ID register with stall hold, redirect flush and a 1-entry skid.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ex_if_redirect,
   input  logic [31:0] ex_if_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] if_id_instr_data,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic [31:0]  if_id_instr_q, if_id_instr_d;
   logic [31:0]  if_id_pc_q, if_id_pc_d;
   logic         if_id_valid_q, if_id_valid_d;

   logic         skid_push, skid_pop, skid_flush, skid_full;
   logic [31:0]  skid_instr, skid_pc;
   logic         rsp_hit, if_id_free, rsp_to_if_id, req_fire;

   fetch_skid_buffer u_skid (
      .clk        (clk),
      .rst        (rst),
      .push       (skid_push),
      .pop        (skid_pop),
      .flush      (skid_flush),
      .push_instr (imem_rsp_data),
      .push_pc    (req_pc_q),
      .full       (skid_full),
      .out_instr  (skid_instr),
      .out_pc     (skid_pc)
   );

   // A new request only follows a response that lands directly in IF/ID, which
   // keeps total buffering at IF/ID plus the single skid entry.
   assign rsp_hit        = (state_q == ST_WAIT) && imem_rsp_valid;
   assign if_id_free     = !stall || !if_id_valid_q;
   assign rsp_to_if_id   = rsp_hit && if_id_free && !skid_full;
   assign imem_req_valid = rst && !skid_full && !ex_if_redirect &&
                           ((state_q == ST_IDLE) || rsp_to_if_id);
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign imem_addr      = pc_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      req_pc_d      = req_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_valid_d = if_id_valid_q;
      skid_push     = 1'b0;
      skid_pop      = 1'b0;
      skid_flush    = 1'b0;
      if (ex_if_redirect) begin
         pc_d          = align_word(ex_if_target);
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
         skid_flush    = 1'b1;
         // A stale response arriving in DROP during a redirect is the last one in flight.
         unique case (state_q)
            ST_WAIT: state_d = imem_rsp_valid ? ST_IDLE : ST_DROP;
            ST_DROP: state_d = imem_rsp_valid ? ST_IDLE : ST_DROP;
            default: state_d = ST_IDLE;
         endcase
      end else begin
         if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
         end
         unique case (state_q)
            ST_WAIT: if (imem_rsp_valid) state_d = req_fire ? ST_WAIT : ST_IDLE;
            ST_DROP: if (imem_rsp_valid) state_d = ST_IDLE;
            default: if (req_fire) state_d = ST_WAIT;
         endcase
         if (if_id_free) begin
            if (skid_full) begin
               if_id_instr_d = skid_instr;
               if_id_pc_d    = skid_pc;
               if_id_valid_d = 1'b1;
               skid_pop      = 1'b1;
            end else if (rsp_hit) begin
               if_id_instr_d = imem_rsp_data;
               if_id_pc_d    = req_pc_q;
               if_id_valid_d = 1'b1;
            end else begin
               if_id_instr_d = NOP_INSTR;
               if_id_valid_d = 1'b0;
            end
         end
         if (rsp_hit && !rsp_to_if_id) skid_push = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         req_pc_q      <= '0;
         if_id_instr_q <= NOP_INSTR;
         if_id_pc_q    <= '0;
         if_id_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         req_pc_q      <= req_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   assign if_id_instr_data = if_id_instr_q;
   assign if_id_pc         = if_id_pc_q;
   assign if_id_valid      = if_id_valid_q;

   // A response with nothing requested means the memory broke the protocol.
   a_no_rsp_in_idle: assert property (@(posedge clk) disable iff (!rst)
      !(imem_rsp_valid && (state_q == ST_IDLE)));

endmodule
